// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU opcodes, FSM states and an opcode legality helper.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OP_AND  = 4'b0010;
    localparam logic [3:0] ALU_OP_OR   = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OP_SLT  = 4'b1000;
    localparam logic [3:0] ALU_OP_SLTU = 4'b1001;
    localparam logic [3:0] ALU_OP_NOP  = 4'b1010;
    localparam logic [3:0] ALU_OP_BGE  = 4'b1011;

    localparam logic [3:0] ALU_OP_ILLEGAL_MIN = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op >= ALU_OP_ILLEGAL_MIN;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response signals of the ALU share arbiter.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_rs1_data;
    logic [32*NUM_REQ-1:0] req_rs2_data;
    logic [4*NUM_REQ-1:0]  req_alu_op;
    logic [31:0]           alu_rs1_data;
    logic [31:0]           alu_rs2_data;
    logic [3:0]            alu_op;
    logic [31:0]           alu_result;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_zero;
    logic                  rsp_overflow;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_rs1_data, req_rs2_data, req_alu_op,
        input  alu_result, alu_zero, alu_overflow, rsp_ready,
        output req_ready, alu_rs1_data, alu_rs2_data, alu_op,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );

    modport master (
        output req_valid, req_rs1_data, req_rs2_data, req_alu_op,
        output alu_result, alu_zero, alu_overflow, rsp_ready,
        input  req_ready, alu_rs1_data, alu_rs2_data, alu_op,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter_rr.sv
// Combinational round-robin arbiter: first valid requester at or after ptr, wrapping at NUM_REQ-1.
module alu_share_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
            if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
                grant[idx[ID_W-1:0]] = 1'b1;
                grant_id             = idx[ID_W-1:0];
                grant_any            = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters, one operation in flight at a time.
//   state   | meaning
//   IDLE    | arbitrate; accept winner, latch its operands/op/id
//   EXEC    | drive latched op to the ALU, capture result into rsp regs
//   RESP    | rsp_valid high, hold until rsp_ready
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     rs1_q, rs1_d;
    logic [31:0]     rs2_q, rs2_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [ID_W:0]      rr_inc;

    alu_share_arbiter_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req_valid (bus.req_valid),
        .ptr       (rr_q),
        .grant     (gnt),
        .grant_id  (gnt_id),
        .grant_any (gnt_any)
    );

    // Illegal opcodes never reach the ALU; it sees a NOP instead.
    assign bus.req_ready    = (state_q == ST_IDLE) ? gnt : '0;
    assign bus.alu_op       = (state_q == ST_EXEC && !op_is_illegal(op_q)) ? op_q : ALU_OP_NOP;
    assign bus.alu_rs1_data = rs1_q;
    assign bus.alu_rs2_data = rs2_q;
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.rsp_err      = rsp_err_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        id_d         = id_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        rr_inc       = {1'b0, gnt_id} + (ID_W+1)'(1);
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    id_d = gnt_id;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt[i]) begin
                            rs1_d = bus.req_rs1_data[32*i +: 32];
                            rs2_d = bus.req_rs2_data[32*i +: 32];
                            op_d  = bus.req_alu_op[4*i +: 4];
                        end
                    end
                    rr_d    = (rr_inc >= NUM_REQ_W) ? '0 : rr_inc[ID_W-1:0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_id_d = id_q;
                if (op_is_illegal(op_q)) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b1;
                    rsp_ovf_d    = 1'b0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = bus.alu_result;
                    rsp_zero_d   = bus.alu_zero;
                    rsp_ovf_d    = bus.alu_overflow;
                    rsp_err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            id_q         <= '0;
            op_q         <= ALU_OP_NOP;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester instance and a 3-requester instance share one clock.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus_a ();
    alu_share_arbiter_if #(.NUM_REQ(3), .ID_W(2)) bus_b ();

    alu_share_arbiter #(.NUM_REQ(2), .ID_W(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    alu_share_arbiter #(.NUM_REQ(3), .ID_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Reference ALU returning {overflow, zero, result}
    function automatic logic [33:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            ALU_OP_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_OP_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_OP_AND:  r = a & b;
            ALU_OP_OR:   r = a | b;
            ALU_OP_XOR:  r = a ^ b;
            ALU_OP_SLL:  r = a << b[4:0];
            ALU_OP_SRL:  r = a >> b[4:0];
            ALU_OP_SRA:  r = $signed(a) >>> b[4:0];
            ALU_OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_OP_SLTU: r = {31'b0, a < b};
            ALU_OP_BGE:  r = {31'b0, $signed(a) >= $signed(b)};
            default:     r = '0;
        endcase
        return {v, (r == 32'd0), r};
    endfunction

    assign {bus_a.alu_overflow, bus_a.alu_zero, bus_a.alu_result} =
        alu_model(bus_a.alu_op, bus_a.alu_rs1_data, bus_a.alu_rs2_data);
    assign {bus_b.alu_overflow, bus_b.alu_zero, bus_b.alu_result} =
        alu_model(bus_b.alu_op, bus_b.alu_rs1_data, bus_b.alu_rs2_data);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req_a(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_a.req_alu_op[4*i +: 4]     = op;
        bus_a.req_rs1_data[32*i +: 32] = a;
        bus_a.req_rs2_data[32*i +: 32] = b;
    endtask

    task automatic set_req_b(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_b.req_alu_op[4*i +: 4]     = op;
        bus_b.req_rs1_data[32*i +: 32] = a;
        bus_b.req_rs2_data[32*i +: 32] = b;
    endtask

    int          ord [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    logic [31:0] exp_res [2] = '{32'h0000_0000, 32'h8000_0000};

    initial begin
        rst_n              = 1'b0;
        bus_a.req_valid    = '0;
        bus_a.req_alu_op   = '0;
        bus_a.req_rs1_data = '0;
        bus_a.req_rs2_data = '0;
        bus_a.rsp_ready    = 1'b1;
        bus_b.req_valid    = '0;
        bus_b.req_alu_op   = '0;
        bus_b.req_rs1_data = '0;
        bus_b.req_rs2_data = '0;
        bus_b.rsp_ready    = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
        chk("rst_alu_op", 32'(bus_a.alu_op), 32'hA);
        chk("rst_alu_rs1", bus_a.alu_rs1_data, 32'd0);
        chk("rst_alu_rs2", bus_a.alu_rs2_data, 32'd0);
        chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus_a.rsp_result, 32'd0);
        chk("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single req0 ADD 7+5
        set_req_a(0, ALU_OP_ADD, 32'd7, 32'd5);
        bus_a.req_valid = 2'b01;
        #1 chk("add_ready", 32'(bus_a.req_ready), 32'h1);
        tick();
        bus_a.req_valid = 2'b00;
        #1 chk("add_exec_op", 32'(bus_a.alu_op), 32'h0);
        chk("add_exec_rs1", bus_a.alu_rs1_data, 32'd7);
        chk("add_exec_rs2", bus_a.alu_rs2_data, 32'd5);
        chk("add_exec_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        tick();
        chk("add_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("add_rsp_id", 32'(bus_a.rsp_id), 32'd0);
        chk("add_rsp_result", bus_a.rsp_result, 32'd12);
        chk("add_rsp_zero", 32'(bus_a.rsp_zero), 32'd0);
        chk("add_rsp_ovf", 32'(bus_a.rsp_overflow), 32'd0);
        tick();
        chk("add_done_valid", 32'(bus_a.rsp_valid), 32'd0);

        // Reset asserted mid-EXEC drops the op
        set_req_a(1, ALU_OP_SUB, 32'd9, 32'd4);
        bus_a.req_valid = 2'b10;
        #1 chk("rst_op_ready", 32'(bus_a.req_ready), 32'h2);
        tick();
        bus_a.req_valid = 2'b00;
        #1 chk("rst_op_exec_op", 32'(bus_a.alu_op), 32'h1);
        rst_n = 1'b0;
        #1 chk("midrst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("midrst_alu_op", 32'(bus_a.alu_op), 32'hA);
        chk("midrst_ready", 32'(bus_a.req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("postrst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        end

        // Both held: SUB 3-3 vs ADD 7FFFFFFF+1, grants alternate from 0
        set_req_a(0, ALU_OP_SUB, 32'd3, 32'd3);
        set_req_a(1, ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1);
        bus_a.req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1 chk("alt_ready", 32'(bus_a.req_ready), (n % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("alt_exec_ready", 32'(bus_a.req_ready), 32'd0);
            tick();
            chk("alt_rsp_id", 32'(bus_a.rsp_id), 32'(n % 2));
            chk("alt_rsp_result", bus_a.rsp_result, exp_res[n % 2]);
            chk("alt_rsp_zero", 32'(bus_a.rsp_zero), (n % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_rsp_ovf", 32'(bus_a.rsp_overflow), (n % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        bus_a.req_valid = 2'b00;

        // SLT -1<1 with 10-cycle stall, req1 (illegal op) waiting
        set_req_a(0, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req_a(1, 4'b1110, 32'd5, 32'd6);
        bus_a.req_valid = 2'b01;
        bus_a.rsp_ready = 1'b0;
        #1 chk("slt_ready", 32'(bus_a.req_ready), 32'h1);
        tick();
        bus_a.req_valid = 2'b10;
        #1 chk("slt_exec_op", 32'(bus_a.alu_op), 32'h8);
        chk("slt_exec_ready", 32'(bus_a.req_ready), 32'd0);
        tick();
        for (int n = 0; n < 10; n++) begin
            chk("stall_valid", 32'(bus_a.rsp_valid), 32'd1);
            chk("stall_result", bus_a.rsp_result, 32'd1);
            chk("stall_id", 32'(bus_a.rsp_id), 32'd0);
            chk("stall_ready", 32'(bus_a.req_ready), 32'd0);
            tick();
        end
        bus_a.rsp_ready = 1'b1;
        #1 chk("hs_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("hs_no_accept", 32'(bus_a.req_ready), 32'd0);
        tick();
        chk("post_hs_valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("post_hs_ready", 32'(bus_a.req_ready), 32'h2);
        tick();

        // Illegal op from req1
        bus_a.req_valid = 2'b00;
        #1 chk("ill_alu_op", 32'(bus_a.alu_op), 32'hA);
        chk("ill_exec_valid", 32'(bus_a.rsp_valid), 32'd0);
        tick();
        chk("ill_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("ill_rsp_err", 32'(bus_a.rsp_err), 32'd1);
        chk("ill_rsp_result", bus_a.rsp_result, 32'd0);
        chk("ill_rsp_zero", 32'(bus_a.rsp_zero), 32'd1);
        chk("ill_rsp_ovf", 32'(bus_a.rsp_overflow), 32'd0);
        chk("ill_rsp_id", 32'(bus_a.rsp_id), 32'd1);
        tick();
        chk("ill_done_valid", 32'(bus_a.rsp_valid), 32'd0);

        // Round-robin wrap with three requesters, then drop req1
        for (int i = 0; i < 3; i++) set_req_b(i, ALU_OP_ADD, 32'(i + 1), 32'd10);
        bus_b.req_valid = 3'b111;
        for (int n = 0; n < 10; n++) begin
            if (n == 6) bus_b.req_valid = 3'b101;
            #1 chk("rr_ready", 32'(bus_b.req_ready), 32'(1) << ord[n]);
            tick();
            tick();
            chk("rr_rsp_id", 32'(bus_b.rsp_id), 32'(ord[n]));
            chk("rr_rsp_result", bus_b.rsp_result, 32'(ord[n] + 11));
            tick();
        end
        bus_b.req_valid = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
